fifo_stream_stamper: RTL and testbench

FIFO_STREAM_STAMPER -- requirements
Module: fifo_stream_stamper

---
 rtl/fifo_stream_pkg.sv | 22 ++
 rtl/stream_sync_fifo.sv | 59 +++++
 rtl/fifo_stream_stamper.sv | 123 ++++++++++++
 tb/tb_fifo_stream_stamper.sv | 487 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_stream_pkg.sv
// Shared definitions for the stream stamper: data/header widths, default marker
// header and the stamper FSM state encoding.
package fifo_stream_pkg;

   localparam int unsigned DataW      = 32;
   localparam int unsigned MarkerHdrW = 4;
   localparam int unsigned PeriodW    = 16;

   localparam logic [MarkerHdrW-1:0] MarkerIdDefault = 4'b0010;

   typedef enum logic [0:0] {
      StPass   = 1'b0,
      StMarker = 1'b1
   } state_e;

   // Marker word: header nibble on top, low timestamp bits below it.
   function automatic logic [DataW-1:0] make_marker(input logic [MarkerHdrW-1:0] id,
                                                    input logic [DataW-1:0]      ts);
      return {id, ts[DataW-MarkerHdrW-1:0]};
   endfunction

endpackage

// File: rtl/stream_sync_fifo.sv
// Synchronous valid/ready FIFO. Storage is a register array, so the head word
// is available straight from a register one cycle after it was written.
module stream_sync_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             wr_valid_i,
   input  logic [WIDTH-1:0] wr_data_i,
   output logic             wr_ready_o,
   output logic             rd_valid_o,
   output logic [WIDTH-1:0] rd_data_o,
   input  logic             rd_pop_i
);

   localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AddrW:0] PtrOne = {{AddrW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem_q [DEPTH];
   // Pointers carry one extra wrap bit to tell full from empty.
   logic [AddrW:0]   wr_ptr_q, wr_ptr_d;
   logic [AddrW:0]   rd_ptr_q, rd_ptr_d;
   logic             full, empty, push, pop;

   // Full/empty decode and pointer advance.
   always_comb begin
      full     = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
                 (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
      empty    = (wr_ptr_q == rd_ptr_q);
      push     = wr_valid_i & ~full;
      pop      = rd_pop_i & ~empty;
      wr_ptr_d = push ? (wr_ptr_q + PtrOne) : wr_ptr_q;
      rd_ptr_d = pop  ? (rd_ptr_q + PtrOne) : rd_ptr_q;
   end

   // Pointer registers; reset empties the buffer.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage array; contents need no reset since the pointers gate visibility.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_q[wr_ptr_q[AddrW-1:0]] <= wr_data_i;
      end
   end

   assign wr_ready_o = ~full;
   assign rd_valid_o = ~empty;
   assign rd_data_o  = mem_q[rd_ptr_q[AddrW-1:0]];

endmodule

// File: rtl/fifo_stream_stamper.sv
// Buffers an upstream word stream and forwards it downstream, inserting a
// timestamped marker word after every MARKER_PERIOD data words.
module fifo_stream_stamper
   import fifo_stream_pkg::*;
#(
   parameter logic [MarkerHdrW-1:0] MARKER_ID = MarkerIdDefault,
   parameter int unsigned           DEPTH     = 4
) (
   input  logic               BUS_CLK,
   input  logic               BUS_RST,
   input  logic [DataW-1:0]   DATA_IN,
   input  logic               WRITE_IN,
   output logic               READY_OUT,
   output logic [DataW-1:0]   DATA_OUT,
   output logic               WRITE_OUT,
   input  logic               READY_IN,
   input  logic [DataW-1:0]   TIMESTAMP,
   input  logic               ENABLE,
   input  logic [PeriodW-1:0] MARKER_PERIOD,
   output logic [31:0]        WORD_COUNT,
   output logic [15:0]        MARKER_COUNT
);

   state_e             state_q, state_d;
   logic [DataW-1:0]   marker_q, marker_d;
   logic [PeriodW-1:0] period_q, period_d, period_inc;
   logic [31:0]        word_cnt_q, word_cnt_d;
   logic [15:0]        marker_cnt_q, marker_cnt_d;

   logic               fifo_ready, head_valid, pop;
   logic [DataW-1:0]   head_data;
   logic               write_out;
   logic [DataW-1:0]   data_out;

   stream_sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (DataW)
   ) u_fifo (
      .clk_i      (BUS_CLK),
      .rst_i      (BUS_RST),
      .wr_valid_i (WRITE_IN & ~BUS_RST),
      .wr_data_i  (DATA_IN),
      .wr_ready_o (fifo_ready),
      .rd_valid_o (head_valid),
      .rd_data_o  (head_data),
      .rd_pop_i   (pop)
   );

   assign period_inc = period_q + 16'd1;

   // Next-state and output decode for the pass/marker FSM.
   always_comb begin
      state_d      = state_q;
      marker_d     = marker_q;
      period_d     = period_q;
      word_cnt_d   = word_cnt_q;
      marker_cnt_d = marker_cnt_q;
      pop          = 1'b0;
      write_out    = 1'b0;
      data_out     = '0;

      case (state_q)
         StPass: begin
            write_out = head_valid;
            data_out  = head_valid ? head_data : '0;
            if (head_valid && READY_IN) begin
               pop        = 1'b1;
               word_cnt_d = word_cnt_q + 32'd1;
               if (ENABLE) begin
                  // >= so that lowering the period below the current count fires at once.
                  if ((MARKER_PERIOD != '0) && (period_inc >= MARKER_PERIOD)) begin
                     period_d = '0;
                     state_d  = StMarker;
                     marker_d = make_marker(MARKER_ID, TIMESTAMP);
                  end else begin
                     period_d = period_inc;
                  end
               end
            end
         end
         StMarker: begin
            write_out = 1'b1;
            data_out  = marker_q;
            if (READY_IN) begin
               marker_cnt_d = marker_cnt_q + 16'd1;
               state_d      = StPass;
            end
         end
         default: begin
            state_d = StPass;
         end
      endcase

      if (!ENABLE) begin
         period_d = '0;
      end
   end

   // State, marker word, period counter and statistics registers.
   always_ff @(posedge BUS_CLK) begin
      if (BUS_RST) begin
         state_q      <= StPass;
         marker_q     <= '0;
         period_q     <= '0;
         word_cnt_q   <= '0;
         marker_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         marker_q     <= marker_d;
         period_q     <= period_d;
         word_cnt_q   <= word_cnt_d;
         marker_cnt_q <= marker_cnt_d;
      end
   end

   // Outputs are forced idle while reset is held.
   assign READY_OUT    = fifo_ready & ~BUS_RST;
   assign WRITE_OUT    = write_out & ~BUS_RST;
   assign DATA_OUT     = BUS_RST ? '0 : data_out;
   assign WORD_COUNT   = word_cnt_q;
   assign MARKER_COUNT = marker_cnt_q;

endmodule

// File: tb/tb_fifo_stream_stamper.sv
// Directed bench for fifo_stream_stamper: one task per scenario, inline checks.
module tb_fifo_stream_stamper;

   logic        BUS_CLK = 1'b0;
   logic        BUS_RST = 1'b1;
   logic [31:0] DATA_IN = '0;
   logic        WRITE_IN = 1'b0;
   logic        READY_OUT;
   logic [31:0] DATA_OUT;
   logic        WRITE_OUT;
   logic        READY_IN = 1'b0;
   logic [31:0] TIMESTAMP = '0;
   logic        ENABLE = 1'b0;
   logic [15:0] MARKER_PERIOD = '0;
   logic [31:0] WORD_COUNT;
   logic [15:0] MARKER_COUNT;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] outq [$];
   int          stable_viol = 0;
   logic        prev_stall  = 1'b0;
   logic [31:0] prev_data   = '0;

   fifo_stream_stamper #(
      .MARKER_ID (4'b0010),
      .DEPTH     (4)
   ) dut (
      .BUS_CLK       (BUS_CLK),
      .BUS_RST       (BUS_RST),
      .DATA_IN       (DATA_IN),
      .WRITE_IN      (WRITE_IN),
      .READY_OUT     (READY_OUT),
      .DATA_OUT      (DATA_OUT),
      .WRITE_OUT     (WRITE_OUT),
      .READY_IN      (READY_IN),
      .TIMESTAMP     (TIMESTAMP),
      .ENABLE        (ENABLE),
      .MARKER_PERIOD (MARKER_PERIOD),
      .WORD_COUNT    (WORD_COUNT),
      .MARKER_COUNT  (MARKER_COUNT)
   );

   always #5 BUS_CLK = ~BUS_CLK;

   // Output monitor: records downstream transfers and checks hold-while-stalled.
   always @(negedge BUS_CLK) begin
      if (BUS_RST) begin
         prev_stall <= 1'b0;
      end else begin
         if (prev_stall && (WRITE_OUT !== 1'b1 || DATA_OUT !== prev_data)) begin
            stable_viol <= stable_viol + 1;
         end
         prev_stall <= (WRITE_OUT === 1'b1) && (READY_IN === 1'b0);
         prev_data  <= DATA_OUT;
         if (WRITE_OUT === 1'b1 && READY_IN === 1'b1) begin
            outq.push_back(DATA_OUT);
         end
      end
   end

   task automatic tick();
      @(posedge BUS_CLK);
      #1;
   endtask

   task automatic apply_reset();
      BUS_RST  = 1'b1;
      WRITE_IN = 1'b0;
      repeat (2) tick();
      BUS_RST = 1'b0;
      outq.delete();
   endtask

   // Offer one word upstream and hold it until accepted (bounded).
   task automatic push(input logic [31:0] d);
      bit ok;
      ok       = 1'b0;
      DATA_IN  = d;
      WRITE_IN = 1'b1;
      for (int t = 0; t < 200 && !ok; t++) begin
         @(negedge BUS_CLK);
         ok = (READY_OUT === 1'b1);
         tick();
      end
      WRITE_IN = 1'b0;
      if (!ok) begin
         n_checks++;
         n_fail++;
         $display("FAIL push_timeout: word %h never accepted, READY_OUT=%b", d, READY_OUT);
      end
   endtask

   task automatic wait_out(input int n, input int budget, input string tag);
      int t;
      t = 0;
      while (outq.size() < n && t < budget) begin
         @(negedge BUS_CLK);
         t++;
      end
      if (outq.size() < n) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_timeout: got %0d output words, need %0d", tag, outq.size(), n);
      end
      repeat (3) tick();
   endtask

   task automatic test_reset();
      BUS_RST = 1'b1;
      repeat (2) tick();
      @(negedge BUS_CLK);
      n_checks++;
      if (WRITE_OUT !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_write_out: got %b want 0", WRITE_OUT);
      end
      n_checks++;
      if (READY_OUT !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_ready_out: got %b want 0", READY_OUT);
      end
      n_checks++;
      if (DATA_OUT !== 32'h0) begin
         n_fail++;
         $display("FAIL rst_data_out: got %h want 0", DATA_OUT);
      end
      tick();
      BUS_RST = 1'b0;
      @(negedge BUS_CLK);
      n_checks++;
      if (READY_OUT !== 1'b1) begin
         n_fail++;
         $display("FAIL post_rst_ready_out: got %b want 1", READY_OUT);
      end
      n_checks++;
      if (WRITE_OUT !== 1'b0) begin
         n_fail++;
         $display("FAIL post_rst_write_out: got %b want 0", WRITE_OUT);
      end
      n_checks++;
      if (WORD_COUNT !== 32'd0 || MARKER_COUNT !== 16'd0) begin
         n_fail++;
         $display("FAIL post_rst_counts: got %0d/%0d want 0/0", WORD_COUNT, MARKER_COUNT);
      end
      tick();
   endtask

   task automatic test_latency();
      apply_reset();
      ENABLE   = 1'b0;
      READY_IN = 1'b1;
      push(32'hDEAD0001);
      @(negedge BUS_CLK);
      n_checks++;
      if (WRITE_OUT !== 1'b1 || DATA_OUT !== 32'hDEAD0001) begin
         n_fail++;
         $display("FAIL latency: got valid=%b data=%h want 1/dead0001", WRITE_OUT, DATA_OUT);
      end
      tick();
      repeat (3) tick();
      n_checks++;
      if (outq.size() != 1) begin
         n_fail++;
         $display("FAIL latency_count: got %0d words want 1", outq.size());
      end
   endtask

   task automatic test_basic_markers();
      logic [31:0] exp [9];
      exp = '{32'd1, 32'd2, 32'd3, 32'h2ABCDEF0, 32'd4, 32'd5, 32'd6, 32'h2ABCDEF0, 32'd7};
      apply_reset();
      MARKER_PERIOD = 16'd3;
      ENABLE        = 1'b1;
      READY_IN      = 1'b1;
      TIMESTAMP     = 32'h0ABCDEF0;
      for (int i = 1; i <= 7; i++) push(i);
      wait_out(9, 100, "basic");
      repeat (5) tick();
      n_checks++;
      if (outq.size() != 9) begin
         n_fail++;
         $display("FAIL basic_len: got %0d want 9", outq.size());
      end
      for (int i = 0; i < 9; i++) begin
         n_checks++;
         if (outq[i] !== exp[i]) begin
            n_fail++;
            $display("FAIL basic_word[%0d]: got %h want %h", i, outq[i], exp[i]);
         end
      end
      n_checks++;
      if (WORD_COUNT !== 32'd7 || MARKER_COUNT !== 16'd2) begin
         n_fail++;
         $display("FAIL basic_counts: got %0d/%0d want 7/2", WORD_COUNT, MARKER_COUNT);
      end
   endtask

   task automatic test_stall();
      int  acc;
      bit  took;
      int  base;
      apply_reset();
      ENABLE        = 1'b0;
      MARKER_PERIOD = '0;
      READY_IN      = 1'b0;
      base          = stable_viol;
      acc           = 0;
      DATA_IN       = 32'h100;
      WRITE_IN      = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge BUS_CLK);
         took = (READY_OUT === 1'b1);
         tick();
         if (took) begin
            acc++;
            DATA_IN = 32'h100 + acc;
         end
      end
      @(negedge BUS_CLK);
      n_checks++;
      if (acc != 4) begin
         n_fail++;
         $display("FAIL stall_accepted: got %0d want 4", acc);
      end
      n_checks++;
      if (READY_OUT !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_ready_out: got %b want 0", READY_OUT);
      end
      n_checks++;
      if (WRITE_OUT !== 1'b1 || DATA_OUT !== 32'h100) begin
         n_fail++;
         $display("FAIL stall_head: got %b/%h want 1/00000100", WRITE_OUT, DATA_OUT);
      end
      tick();
      READY_IN = 1'b1;
      for (int c = 0; c < 50 && acc < 8; c++) begin
         @(negedge BUS_CLK);
         took = (READY_OUT === 1'b1);
         tick();
         if (took) begin
            acc++;
            DATA_IN = 32'h100 + acc;
         end
      end
      WRITE_IN = 1'b0;
      wait_out(8, 100, "stall");
      n_checks++;
      if (outq.size() != 8) begin
         n_fail++;
         $display("FAIL stall_len: got %0d want 8", outq.size());
      end
      for (int i = 0; i < 8; i++) begin
         n_checks++;
         if (outq[i] !== 32'h100 + i) begin
            n_fail++;
            $display("FAIL stall_word[%0d]: got %h want %h", i, outq[i], 32'h100 + i);
         end
      end
      n_checks++;
      if (stable_viol != base) begin
         n_fail++;
         $display("FAIL stall_hold: got %0d unstable cycles want 0", stable_viol - base);
      end
   endtask

   task automatic test_enable_off();
      int mism;
      apply_reset();
      ENABLE        = 1'b0;
      MARKER_PERIOD = 16'd3;
      READY_IN      = 1'b1;
      TIMESTAMP     = 32'h01234567;
      for (int i = 0; i < 100; i++) push(32'h5000 + i);
      wait_out(100, 400, "enoff");
      mism = 0;
      for (int i = 0; i < 100; i++) begin
         if (outq[i] !== 32'h5000 + i) mism++;
      end
      n_checks++;
      if (outq.size() != 100 || mism != 0) begin
         n_fail++;
         $display("FAIL enoff_seq: got len %0d with %0d bad words want 100/0", outq.size(), mism);
      end
      n_checks++;
      if (WORD_COUNT !== 32'd100 || MARKER_COUNT !== 16'd0) begin
         n_fail++;
         $display("FAIL enoff_counts: got %0d/%0d want 100/0", WORD_COUNT, MARKER_COUNT);
      end
   endtask

   task automatic test_reset_in_marker();
      logic [31:0] exp [4];
      bit          found;
      exp = '{32'h31, 32'h32, 32'h20001234, 32'h33};
      apply_reset();
      ENABLE        = 1'b1;
      MARKER_PERIOD = 16'd2;
      READY_IN      = 1'b1;
      TIMESTAMP     = 32'h00001234;
      push(32'h11);
      push(32'h12);
      found = 1'b0;
      for (int t = 0; t < 20 && !found; t++) begin
         @(negedge BUS_CLK);
         if (WRITE_OUT === 1'b1 && DATA_OUT === 32'h20001234) begin
            found    = 1'b1;
            READY_IN = 1'b0;
         end
      end
      n_checks++;
      if (!found) begin
         n_fail++;
         $display("FAIL rstmk_enter: marker 20001234 not seen, got %h", DATA_OUT);
      end
      tick();
      push(32'h21);
      push(32'h22);
      push(32'h23);
      @(negedge BUS_CLK);
      n_checks++;
      if (WRITE_OUT !== 1'b1 || DATA_OUT !== 32'h20001234) begin
         n_fail++;
         $display("FAIL rstmk_hold: got %b/%h want 1/20001234", WRITE_OUT, DATA_OUT);
      end
      tick();
      BUS_RST = 1'b1;
      tick();
      BUS_RST = 1'b0;
      @(negedge BUS_CLK);
      n_checks++;
      if (WRITE_OUT !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmk_write_out: got %b want 0", WRITE_OUT);
      end
      n_checks++;
      if (WORD_COUNT !== 32'd0 || MARKER_COUNT !== 16'd0) begin
         n_fail++;
         $display("FAIL rstmk_counts: got %0d/%0d want 0/0", WORD_COUNT, MARKER_COUNT);
      end
      tick();
      outq.delete();
      READY_IN = 1'b1;
      push(32'h31);
      push(32'h32);
      push(32'h33);
      wait_out(4, 50, "rstmk");
      repeat (3) tick();
      n_checks++;
      if (outq.size() != 4) begin
         n_fail++;
         $display("FAIL rstmk_len: got %0d want 4", outq.size());
      end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (outq[i] !== exp[i]) begin
            n_fail++;
            $display("FAIL rstmk_word[%0d]: got %h want %h", i, outq[i], exp[i]);
         end
      end
   endtask

   task automatic test_period_change();
      logic [31:0] exp [10];
      exp = '{32'h41, 32'h42, 32'h43, 32'h44, 32'h45, 32'h46, 32'h2FFF0000,
              32'h47, 32'h48, 32'h2FFF0000};
      apply_reset();
      ENABLE        = 1'b1;
      MARKER_PERIOD = 16'd10;
      READY_IN      = 1'b1;
      TIMESTAMP     = 32'hFFFF0000;
      for (int i = 0; i < 5; i++) push(32'h41 + i);
      wait_out(5, 50, "perchg_a");
      MARKER_PERIOD = 16'd2;
      for (int i = 5; i < 8; i++) push(32'h41 + i);
      wait_out(10, 50, "perchg_b");
      repeat (3) tick();
      n_checks++;
      if (outq.size() != 10) begin
         n_fail++;
         $display("FAIL perchg_len: got %0d want 10", outq.size());
      end
      for (int i = 0; i < 10; i++) begin
         n_checks++;
         if (outq[i] !== exp[i]) begin
            n_fail++;
            $display("FAIL perchg_word[%0d]: got %h want %h", i, outq[i], exp[i]);
         end
      end
      n_checks++;
      if (WORD_COUNT !== 32'd8 || MARKER_COUNT !== 16'd2) begin
         n_fail++;
         $display("FAIL perchg_counts: got %0d/%0d want 8/2", WORD_COUNT, MARKER_COUNT);
      end
   endtask

   task automatic test_random_stall();
      int  n_words;
      int  idx;
      int  cyc;
      int  pos;
      int  mism;
      int  first_bad;
      int  base;
      bit  acc;
      n_words = 10000;
      apply_reset();
      ENABLE        = 1'b1;
      MARKER_PERIOD = 16'd16;
      TIMESTAMP     = 32'h95555555;
      base          = stable_viol;
      idx           = 0;
      cyc           = 0;
      while (idx < n_words && cyc < 60000) begin
         if (!WRITE_IN && $urandom_range(0, 3) != 0) begin
            WRITE_IN = 1'b1;
            DATA_IN  = 32'hA0000000 + idx;
         end
         READY_IN = ($urandom_range(0, 3) != 0);
         @(negedge BUS_CLK);
         acc = WRITE_IN && (READY_OUT === 1'b1);
         tick();
         if (acc) begin
            idx++;
            WRITE_IN = 1'b0;
         end
         cyc++;
      end
      WRITE_IN = 1'b0;
      READY_IN = 1'b1;
      n_checks++;
      if (idx != n_words) begin
         n_fail++;
         $display("FAIL rand_input_timeout: accepted %0d want %0d", idx, n_words);
      end
      wait_out(10625, 3000, "rand");
      mism      = 0;
      first_bad = -1;
      pos       = 0;
      for (int i = 1; i <= n_words; i++) begin
         if (outq[pos] !== 32'hA0000000 + (i - 1)) begin
            mism++;
            if (first_bad < 0) first_bad = pos;
         end
         pos++;
         if (i % 16 == 0) begin
            if (outq[pos] !== 32'h25555555) begin
               mism++;
               if (first_bad < 0) first_bad = pos;
            end
            pos++;
         end
      end
      n_checks++;
      if (outq.size() != 10625 || mism != 0) begin
         n_fail++;
         $display("FAIL rand_seq: got len %0d, %0d bad words (first at %0d) want 10625/0",
                  outq.size(), mism, first_bad);
      end
      n_checks++;
      if (WORD_COUNT !== 32'd10000 || MARKER_COUNT !== 16'd625) begin
         n_fail++;
         $display("FAIL rand_counts: got %0d/%0d want 10000/625", WORD_COUNT, MARKER_COUNT);
      end
      n_checks++;
      if (stable_viol != base) begin
         n_fail++;
         $display("FAIL rand_hold: got %0d unstable cycles want 0", stable_viol - base);
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_basic_markers();
      test_stall();
      test_enable_off();
      test_reset_in_marker();
      test_period_change();
      test_random_stall();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
